id_exe_reg: RTL and testbench

- Pipeline register between the decode (ID) and execute (EXE) stages.
- Captures decoded control and operands each cycle and presents them to the EXE stage: val2 generation, ALU, branch-target adder.
- Supports stall (freeze), flush (branch taken) and bubble insertion (valid_in low).
- Also registers the load/store detect consumed by val2 generation, so EXE needs no combinational decode.

---
 rtl/id_exe_reg.sv | 135 +++++++++++++
 tb/tb_id_exe_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush > freeze > load priority and bubble gating of control bits.
// Optional forwarding source fields are enabled by defining ID_EXE_FWD_EN.
module id_exe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shifter_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        status_in,
`ifdef ID_EXE_FWD_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              fwd_valid_out,
`endif
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic              mem_access_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shifter_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        status_out
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              mem_access;
    logic [CMD_W-1:0]  exe_cmd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shifter_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        status;
`ifdef ID_EXE_FWD_EN
    logic [3:0]        src1;
    logic [3:0]        src2;
`endif
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!freeze) begin
      stage_d.valid           = valid_in;
      // Bubbles must never cause side effects downstream, whatever the decoder drives.
      stage_d.wb_en           = wb_en_in & valid_in;
      stage_d.mem_r_en        = mem_r_en_in & valid_in;
      stage_d.mem_w_en        = mem_w_en_in & valid_in;
      stage_d.b               = b_in & valid_in;
      stage_d.s               = s_in & valid_in;
      stage_d.mem_access      = (mem_r_en_in | mem_w_en_in) & valid_in;
      stage_d.exe_cmd         = exe_cmd_in;
      stage_d.pc              = pc_in;
      stage_d.val_rn          = val_rn_in;
      stage_d.val_rm          = val_rm_in;
      stage_d.imm             = imm_in;
      stage_d.shifter_operand = shifter_operand_in;
      stage_d.signed_imm_24   = signed_imm_24_in;
      stage_d.dest            = dest_in;
      stage_d.status          = status_in;
`ifdef ID_EXE_FWD_EN
      stage_d.src1            = src1_in;
      stage_d.src2            = src2_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_out           = stage_q.valid;
  assign wb_en_out           = stage_q.wb_en;
  assign mem_r_en_out        = stage_q.mem_r_en;
  assign mem_w_en_out        = stage_q.mem_w_en;
  assign b_out               = stage_q.b;
  assign s_out               = stage_q.s;
  assign mem_access_out      = stage_q.mem_access;
  assign exe_cmd_out         = stage_q.exe_cmd;
  assign pc_out              = stage_q.pc;
  assign val_rn_out          = stage_q.val_rn;
  assign val_rm_out          = stage_q.val_rm;
  assign imm_out             = stage_q.imm;
  assign shifter_operand_out = stage_q.shifter_operand;
  assign signed_imm_24_out   = stage_q.signed_imm_24;
  assign dest_out            = stage_q.dest;
  assign status_out          = stage_q.status;
`ifdef ID_EXE_FWD_EN
  assign src1_out            = stage_q.src1;
  assign src2_out            = stage_q.src2;
  assign fwd_valid_out       = stage_q.valid;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: driver pushes expected stage contents, monitor pops and compares.
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic        mem_access;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shifter_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  status;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   flush = 1'b0;
  logic   freeze = 1'b0;
  stage_t in_s = '0;
  stage_t out_s;
  stage_t model;
  stage_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
`ifdef ID_EXE_FWD_EN
  logic [3:0] src1_out, src2_out;
  logic       fwd_valid_out;
`endif

  always #5 clk = ~clk;

  id_exe_reg #(.DATA_W(32), .CMD_W(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .freeze              (freeze),
    .valid_in            (in_s.valid),
    .wb_en_in            (in_s.wb_en),
    .mem_r_en_in         (in_s.mem_r_en),
    .mem_w_en_in         (in_s.mem_w_en),
    .b_in                (in_s.b),
    .s_in                (in_s.s),
    .exe_cmd_in          (in_s.exe_cmd),
    .pc_in               (in_s.pc),
    .val_rn_in           (in_s.val_rn),
    .val_rm_in           (in_s.val_rm),
    .imm_in              (in_s.imm),
    .shifter_operand_in  (in_s.shifter_operand),
    .signed_imm_24_in    (in_s.signed_imm_24),
    .dest_in             (in_s.dest),
    .status_in           (in_s.status),
`ifdef ID_EXE_FWD_EN
    .src1_in             (in_s.dest),
    .src2_in             (in_s.status),
    .src1_out            (src1_out),
    .src2_out            (src2_out),
    .fwd_valid_out       (fwd_valid_out),
`endif
    .valid_out           (out_s.valid),
    .wb_en_out           (out_s.wb_en),
    .mem_r_en_out        (out_s.mem_r_en),
    .mem_w_en_out        (out_s.mem_w_en),
    .b_out               (out_s.b),
    .s_out               (out_s.s),
    .mem_access_out      (out_s.mem_access),
    .exe_cmd_out         (out_s.exe_cmd),
    .pc_out              (out_s.pc),
    .val_rn_out          (out_s.val_rn),
    .val_rm_out          (out_s.val_rm),
    .imm_out             (out_s.imm),
    .shifter_operand_out (out_s.shifter_operand),
    .signed_imm_24_out   (out_s.signed_imm_24),
    .dest_out            (out_s.dest),
    .status_out          (out_s.status)
  );

  function automatic stage_t rand_fields();
    stage_t f;
    f.valid           = 1'($urandom);
    f.wb_en           = 1'($urandom);
    f.mem_r_en        = 1'($urandom);
    f.mem_w_en        = 1'($urandom);
    f.b               = 1'($urandom);
    f.s               = 1'($urandom);
    f.mem_access      = 1'b0;
    f.exe_cmd         = 4'($urandom);
    f.pc              = $urandom;
    f.val_rn          = $urandom;
    f.val_rm          = $urandom;
    f.imm             = 1'($urandom);
    f.shifter_operand = 12'($urandom);
    f.signed_imm_24   = 24'($urandom);
    f.dest            = 4'($urandom);
    f.status          = 4'($urandom);
    return f;
  endfunction

  // Reference: what EXE should see after the next edge, from the stage rules.
  task automatic drive(input stage_t f, input logic fl, input logic fz);
    @(negedge clk);
    in_s   = f;
    flush  = fl;
    freeze = fz;
    if (fl) begin
      model = '0;
    end else if (!fz) begin
      model            = f;
      model.wb_en      = f.valid && f.wb_en;
      model.mem_r_en   = f.valid && f.mem_r_en;
      model.mem_w_en   = f.valid && f.mem_w_en;
      model.b          = f.valid && f.b;
      model.s          = f.valid && f.s;
      model.mem_access = f.valid && (f.mem_r_en || f.mem_w_en);
    end
    exp_q.push_back(model);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_s !== '0) begin
      errors++;
      $display("FAIL %s got %h exp 0", name, out_s);
    end
  endtask

  task automatic check_drained();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  // Monitor
  initial begin
    stage_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_s !== e) begin
          errors++;
          $display("FAIL stage t=%0t got %h exp %h", $time, out_s, e);
        end
      end
    end
  end

  initial begin
    stage_t f;
    model = '0;
    in_s  = rand_fields();
    in_s.valid = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_zero("reset_initial");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal load
    f = '0;
    f.valid = 1'b1; f.wb_en = 1'b1; f.exe_cmd = 4'b0010; f.pc = 32'h0000_0010;
    f.val_rm = 32'hF000_0001; f.shifter_operand = 12'h0E3;
    drive(f, 1'b0, 1'b0);
    // Store detect, then the same as a bubble
    f = '0;
    f.valid = 1'b1; f.mem_w_en = 1'b1; f.val_rn = 32'h1234_5678;
    drive(f, 1'b0, 1'b0);
    f.valid = 1'b0; f.val_rn = 32'h8765_4321;
    drive(f, 1'b0, 1'b0);
    // Illegal load+store from decoder still captured
    f.valid = 1'b1; f.mem_r_en = 1'b1;
    drive(f, 1'b0, 1'b0);
    // Freeze holds pc
    f = '0; f.valid = 1'b1; f.pc = 32'h20;
    drive(f, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      f.pc = 32'h20 + 32'(4 * i);
      drive(f, 1'b0, 1'b1);
    end
    drive(f, 1'b0, 1'b0);
    // Flush beats freeze
    f = '0; f.valid = 1'b1; f.wb_en = 1'b1; f.dest = 4'd5;
    drive(f, 1'b0, 1'b0);
    drive(rand_fields(), 1'b1, 1'b1);
    // Flush then branch back-to-back
    drive(rand_fields(), 1'b1, 1'b0);
    f = '0; f.valid = 1'b1; f.b = 1'b1; f.signed_imm_24 = 24'hFFFFFE;
    drive(f, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(rand_fields(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end
    check_drained();

    // Asynchronous reset mid-cycle while frozen
    @(posedge clk);
    #3;
    in_s   = rand_fields();
    in_s.valid = 1'b1;
    freeze = 1'b1;
    rst_n  = 1'b0;
    #1 check_zero("reset_async");
    @(posedge clk);
    #1 check_zero("reset_during_freeze");
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
    for (int i = 0; i < 20; i++) begin
      drive(rand_fields(), 1'b0, ($urandom_range(0, 3) == 0));
    end
    check_drained();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
